servo_jr_rx: RTL and testbench

- Receiver and decoder for JR-style servo PWM, the inverse of the team's servo driver.
- Measures the high time of each pulse on SERVO_i and maps it back to an 8-bit position on DAT_o.
- Flags each new sample with VALID_o and tracks signal presence on LOCK_o.
- Used for loopback test of the servo driver and for decoding external RC receiver channels.

---
 rtl/servo_jr_rx.sv | 203 ++++++++++++++++++++
 tb/tb_servo_jr_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_jr_rx.sv
// servo_jr_rx: JR-style servo PWM receiver. Measures the high time of each
// pulse on SERVO_i and maps it back to an 8-bit position on DAT_o.
// Optional build macro SERVO_JR_RX_GLITCH_FILTER_EN adds a 3-sample stability
// filter after the synchronizer (edge detect moves from 3 to 5 cycles).
// XARST_i is expected to carry an external pull-up at the pad.
module servo_jr_rx #(
   parameter int unsigned C_FCK      = 48_000_000,
   parameter int unsigned C_TBOTTOM  = 500,
   parameter int unsigned C_TTOP     = 2_400,
   parameter int unsigned C_TMIN_PLS = 250,
   parameter int unsigned C_TMAX_PLS = 3_000,
   parameter int unsigned C_TTIMEOUT = 50_000
) (
   input  logic       CK_i,
   input  logic       XARST_i,
   input  logic       SERVO_i,
   output logic [7:0] DAT_o,
   output logic       VALID_o,
   output logic       LOCK_o,
   output logic       ERR_o
);

   localparam int unsigned C_FCK_KHZ = C_FCK / 1000;
   localparam int unsigned C_BOTTOM  = C_TBOTTOM * C_FCK_KHZ / 1000;
   localparam int unsigned C_TOP     = C_TTOP * C_FCK_KHZ / 1000;
   localparam int unsigned C_MINP    = C_TMIN_PLS * C_FCK_KHZ / 1000;
   localparam int unsigned C_MAXP    = C_TMAX_PLS * C_FCK_KHZ / 1000;
   localparam int unsigned C_TOUT    = C_TTIMEOUT * C_FCK_KHZ / 1000;
   localparam int unsigned C_R       = C_TOP - C_BOTTOM;
   localparam int unsigned WW        = $clog2(C_MAXP + 2);
   localparam int unsigned PW        = $clog2(C_TOUT + 1);
   localparam int unsigned RB        = $clog2(C_R + 1);
   localparam int unsigned RW1       = RB + 1;
   localparam int unsigned NW        = RB + 8;

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_OVER, S_LOW} pst_e;
   typedef enum logic       {D_IDLE, D_ITER} dst_e;

   logic          s1_q, s2_q, lvl_q;
   logic          filt_c, rise_c, fall_c, tout_c, done_c;
   pst_e          st_q;
   logic [WW-1:0] w_q, dw_q, diff_c;
   logic [PW-1:0] p_q;
   logic          ld_q, lock_q, err_q;
   dst_e          d_st_q;
   logic [RB-1:0] rem_q;
   logic [7:0]    nlo_q, q_q, dat_q;
   logic [2:0]    cnt_q;
   logic          valid_q;
   logic [NW-1:0] num_c;
   logic [RB:0]   trial_c;
   logic          ge_c;

   // Two-stage synchronizer; idles high so a pulse already high at reset
   // release never looks like a rise.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= SERVO_i;
         s2_q <= s1_q;
      end
   end

`ifdef SERVO_JR_RX_GLITCH_FILTER_EN
   logic h0_q, h1_q;

   // Sample history for the stability filter
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         h0_q <= 1'b1;
         h1_q <= 1'b1;
      end else begin
         h0_q <= s2_q;
         h1_q <= h0_q;
      end
   end

   assign filt_c = ((s2_q == h0_q) && (h0_q == h1_q)) ? s2_q : lvl_q;
`else
   assign filt_c = s2_q;
`endif

   // Edge-detect register
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) lvl_q <= 1'b1;
      else          lvl_q <= filt_c;
   end

   assign rise_c = filt_c & ~lvl_q;
   assign fall_c = ~filt_c & lvl_q;
   assign tout_c = (st_q != S_IDLE) && (p_q == PW'(C_TOUT - 1));
   assign done_c = (d_st_q == D_ITER) && (cnt_q == 3'd7);

   // Pulse FSM: width measurement, period timeout, lock and error reporting
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         st_q   <= S_IDLE;
         w_q    <= '0;
         dw_q   <= '0;
         p_q    <= '0;
         ld_q   <= 1'b0;
         lock_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         err_q <= 1'b0;
         ld_q  <= 1'b0;
         if (st_q != S_IDLE && p_q != PW'(C_TOUT)) p_q <= p_q + PW'(1);
         if (done_c) lock_q <= 1'b1;
         if (tout_c) begin
            st_q   <= S_IDLE;
            err_q  <= 1'b1;
            lock_q <= 1'b0;
         end else begin
            case (st_q)
               S_IDLE, S_LOW: begin
                  if (rise_c) begin
                     st_q <= S_HIGH;
                     w_q  <= WW'(1);
                     p_q  <= '0;
                  end
               end
               S_HIGH: begin
                  if (fall_c) begin
                     st_q <= S_LOW;
                     if (w_q < WW'(C_MINP)) begin
                        err_q  <= 1'b1;
                        lock_q <= 1'b0;
                     end else begin
                        ld_q <= 1'b1;
                        dw_q <= w_q;
                     end
                  end else if (w_q == WW'(C_MAXP)) begin
                     st_q   <= S_OVER;
                     err_q  <= 1'b1;
                     lock_q <= 1'b0;
                  end else begin
                     w_q <= w_q + WW'(1);
                  end
               end
               S_OVER:  if (fall_c) st_q <= S_LOW;
               default: st_q <= S_IDLE;
            endcase
         end
      end
   end

   // Divider numerator: clamps map to 0 / 255, otherwise ceil-biased offset
   assign diff_c = dw_q - WW'(C_BOTTOM);
   always_comb begin
      num_c = '0;
      if (dw_q <= WW'(C_BOTTOM))  num_c = '0;
      else if (dw_q >= WW'(C_TOP)) num_c = NW'(256 * C_R - 1);
      else                         num_c = (NW'(diff_c) << 8) + NW'(C_R - 1);
   end

   assign trial_c = {rem_q, nlo_q[7]};
   assign ge_c    = (trial_c >= RW1'(C_R));

   // Serial restoring divider: one load cycle then 8 quotient bits
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         d_st_q  <= D_IDLE;
         rem_q   <= '0;
         nlo_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         dat_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (d_st_q)
            D_IDLE: begin
               if (ld_q) begin
                  rem_q  <= num_c[NW-1:8];
                  nlo_q  <= num_c[7:0];
                  cnt_q  <= '0;
                  d_st_q <= D_ITER;
               end
            end
            D_ITER: begin
               rem_q <= ge_c ? RB'(trial_c - RW1'(C_R)) : RB'(trial_c);
               nlo_q <= {nlo_q[6:0], 1'b0};
               q_q   <= {q_q[6:0], ge_c};
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  dat_q   <= {q_q[6:0], ge_c};
                  valid_q <= 1'b1;
                  d_st_q  <= D_IDLE;
               end
            end
            default: d_st_q <= D_IDLE;
         endcase
      end
   end

   assign DAT_o   = dat_q;
   assign VALID_o = valid_q;
   assign LOCK_o  = lock_q;
   assign ERR_o   = err_q;

endmodule

// File: tb/tb_servo_jr_rx.sv
// Bench for servo_jr_rx, scaled to 100 kHz so every time constant is a
// small cycle count: bottom 50, top 320, min 25, max 400, timeout 1000.
module tb_servo_jr_rx;

   localparam int B    = 50;
   localparam int T    = 320;
   localparam int R    = T - B;
   localparam int MAXP = 400;
   localparam int TOUT = 1000;
`ifdef SERVO_JR_RX_GLITCH_FILTER_EN
   localparam int EDLY = 5;
`else
   localparam int EDLY = 3;
`endif

   typedef struct {
      int     dat;
      longint cyc;
   } exp_t;

   logic       CK_i = 1'b0;
   logic       XARST_i;
   logic       SERVO_i;
   logic [7:0] DAT_o;
   logic       VALID_o;
   logic       LOCK_o;
   logic       ERR_o;

   longint cyc = 0;
   int     n_vec = 0;
   int     n_bad = 0;
   int     err_cnt = 0;
   longint last_err = -1;
   exp_t   sb[$];
   exp_t   mon_e;

   servo_jr_rx #(
      .C_FCK(100_000), .C_TBOTTOM(500), .C_TTOP(3200),
      .C_TMIN_PLS(250), .C_TMAX_PLS(4000), .C_TTIMEOUT(10_000)
   ) dut (
      .CK_i(CK_i), .XARST_i(XARST_i), .SERVO_i(SERVO_i),
      .DAT_o(DAT_o), .VALID_o(VALID_o), .LOCK_o(LOCK_o), .ERR_o(ERR_o)
   );

   always #5 CK_i = ~CK_i;
   always @(posedge CK_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference decode: clamp below bottom / above top, else ceil of scaled offset
   function automatic int model(input int w);
      int v;
      if (w <= B) return 0;
      if (w >= T) return 255;
      v = ((w - B) * 256 + R - 1) / R;
      return (v > 255) ? 255 : v;
   endfunction

   // Output monitor: score every VALID_o against the queue, count ERR_o cycles
   always @(negedge CK_i) begin
      if (ERR_o) begin
         err_cnt++;
         last_err = cyc;
      end
      if (VALID_o) begin
         if (sb.size() == 0) begin
            chk("valid_unexpected", VALID_o, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("dat", DAT_o, mon_e.dat);
            chk("valid_latency", cyc, mon_e.cyc);
         end
      end
   end

   // One high pulse of w cycles followed by lo cycles low; ed<0 means no decode
   task automatic pulse(input int w, input int lo, input int ed,
                        output longint rc, output longint fc);
      @(posedge CK_i); #1;
      SERVO_i = 1'b1;
      rc = cyc;
      repeat (w) @(posedge CK_i);
      #1;
      SERVO_i = 1'b0;
      fc = cyc;
      if (ed >= 0) sb.push_back('{dat: ed, cyc: fc + EDLY + 9});
      repeat (lo) @(posedge CK_i);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      longint rc, fc;
      int     e0;
      SERVO_i = 1'b0;
      XARST_i = 1'b0;
      repeat (5) @(negedge CK_i);
      chk("rst_dat", DAT_o, 0);
      chk("rst_valid", VALID_o, 0);
      chk("rst_lock", LOCK_o, 0);
      chk("rst_err", ERR_o, 0);
      XARST_i = 1'b1;
      repeat (10) @(posedge CK_i);
      @(negedge CK_i);
      chk("lock_before_pulse", LOCK_o, 0);

      // Bottom, midscale and near-top widths
      pulse(B, 40, 0, rc, fc);
      @(negedge CK_i);
      chk("lock_after_first", LOCK_o, 1);
      pulse(185, 40, 128, rc, fc);
      pulse(T - 1, 40, 255, rc, fc);

      // Driver loopback: driver encodes floor(d*R/256) above bottom
      for (int d = 0; d < 256; d++) pulse(B + d * R / 256, 20, d, rc, fc);

      // Clamped widths decode without error
      e0 = err_cnt;
      pulse(40, 40, model(40), rc, fc);
      pulse(380, 40, model(380), rc, fc);
      chk("clamp_no_err", err_cnt - e0, 0);

      // Too-short pulse
      e0 = err_cnt;
      pulse(10, 40, -1, rc, fc);
      @(negedge CK_i);
      chk("short_err_count", err_cnt - e0, 1);
      chk("short_err_cycle", last_err, fc + EDLY);
      chk("short_lock", LOCK_o, 0);
      chk("short_dat_kept", DAT_o, 255);

      // Held high: overflow error, then the period timeout from that rise
      e0 = err_cnt;
      pulse(600, 0, -1, rc, fc);
      chk("over_err_count", err_cnt - e0, 1);
      chk("over_err_cycle", last_err, rc + EDLY + MAXP);
      repeat (500) @(posedge CK_i);
      @(negedge CK_i);
      chk("over_tout_cycle", last_err, rc + EDLY + TOUT);
      pulse(200, 40, model(200), rc, fc);
      @(negedge CK_i);
      chk("relock_after_over", LOCK_o, 1);

      // Signal stops after a valid pulse
      pulse(200, 0, model(200), rc, fc);
      e0 = err_cnt;
      for (int i = 0; i < TOUT + 100 && err_cnt == e0; i++) @(negedge CK_i);
      chk("tout_cycle", last_err, rc + EDLY + TOUT);
      chk("tout_lock", LOCK_o, 0);
      repeat (TOUT + 100) @(posedge CK_i);
      chk("tout_once", err_cnt - e0, 1);
      pulse(185, 40, 128, rc, fc);
      @(negedge CK_i);
      chk("relock_after_tout", LOCK_o, 1);

      // Reset in the middle of a divide
      pulse(300, 4, -1, rc, fc);
      @(negedge CK_i);
      XARST_i = 1'b0;
      @(negedge CK_i);
      chk("middiv_dat", DAT_o, 0);
      chk("middiv_valid", VALID_o, 0);
      chk("middiv_lock", LOCK_o, 0);
      chk("middiv_err", ERR_o, 0);

      // Pulse already high at reset release is not decoded
      SERVO_i = 1'b1;
      repeat (3) @(negedge CK_i);
      XARST_i = 1'b1;
      repeat (30) @(posedge CK_i);
      #1;
      SERVO_i = 1'b0;
      repeat (30) @(posedge CK_i);
      @(negedge CK_i);
      chk("rst_high_lock", LOCK_o, 0);
      chk("rst_high_dat", DAT_o, 0);
      pulse(185, 40, 128, rc, fc);
      @(negedge CK_i);
      chk("lock_after_rst", LOCK_o, 1);

`ifdef SERVO_JR_RX_GLITCH_FILTER_EN
      // Two-cycle glitches in the low time are filtered out
      e0 = err_cnt;
      for (int g = 0; g < 3; g++) begin
         @(posedge CK_i); #1;
         SERVO_i = 1'b1;
         repeat (2) @(posedge CK_i);
         #1;
         SERVO_i = 1'b0;
         repeat (20) @(posedge CK_i);
      end
      @(negedge CK_i);
      chk("glitch_no_err", err_cnt - e0, 0);
      chk("glitch_lock", LOCK_o, 1);
      pulse(250, 40, model(250), rc, fc);
`endif

      repeat (20) @(posedge CK_i);
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
